// File: rtl/oerv_store_ser2par_if.sv
// Store-data and Wishbone write signals of the oerv store serial-to-parallel assembler.
// The master side feeds bytes and requests; the slave side is the assembler itself.
interface oerv_store_ser2par_if;
    logic        i_dat_en;
    logic [1:0]  i_cnt;
    logic [7:0]  i_dat;
    logic [1:0]  i_size;
    logic [1:0]  i_lsb;
    logic        i_req;
    logic        o_ready;
    logic        o_wb_cyc;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic        i_wb_ack;
    logic        o_done;
    logic        o_misalign;

    modport master (
        output i_dat_en, i_cnt, i_dat, i_size, i_lsb, i_req, i_wb_ack,
        input  o_ready, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_dat, o_done, o_misalign
    );

    modport slave (
        input  i_dat_en, i_cnt, i_dat, i_size, i_lsb, i_req, i_wb_ack,
        output o_ready, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_dat, o_done, o_misalign
    );
endinterface

// File: rtl/oerv_store_ser2par.sv
// Collects four LSB-first store bytes into a word, replicates it by access size
// and issues one Wishbone write cycle per request.
module oerv_store_ser2par #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    oerv_store_ser2par_if.slave         io
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_READY,
        S_BUS
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_exp;
    logic [31:0] r_data;
    logic [1:0]  r_size;
    logic [1:0]  r_lsb;
    logic        r_done;
    logic        r_misalign;

    logic        w_accept;
    logic        w_latch;
    logic        w_done_nxt;
    logic        w_misalign_nxt;
    logic        w_byte0;
    logic        w_inorder;
    logic        w_misaligned;
    logic [3:0]  w_sel;
    logic [31:0] w_wdat;

    assign w_byte0   = io.i_dat_en && (io.i_cnt == 2'd0);
    assign w_inorder = io.i_dat_en && (io.i_cnt == r_exp);

    // Uses the live request attributes: the decision is made on the i_req cycle
    assign w_misaligned = io.i_size[1] ? (io.i_lsb != 2'b00)
                                       : (io.i_size[0] && io.i_lsb[0]);

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_latch        = 1'b0;
        w_done_nxt     = 1'b0;
        w_misalign_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_byte0) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (w_byte0 || w_inorder) begin
                    w_accept = 1'b1;
                    if (io.i_cnt == 2'd3)
                        w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                // A request takes priority over a restarting byte 0 in the same cycle
                if (io.i_req) begin
                    w_latch = 1'b1;
                    if (ALIGN_CHECK && w_misaligned) begin
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_state_nxt    = S_BUS;
                    end
                end else if (w_byte0) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_BUS: begin
                if (io.i_wb_ack) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_exp      <= '0;
            r_data     <= '0;
            r_size     <= '0;
            r_lsb      <= '0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_misalign <= w_misalign_nxt;
            if (w_accept) begin
                r_data[{io.i_cnt, 3'b000} +: 8] <= io.i_dat;
                r_exp                           <= io.i_cnt + 2'd1;
            end
            if (w_latch) begin
                r_size <= io.i_size;
                r_lsb  <= io.i_lsb;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        if (r_state == S_BUS) begin
            if (r_size[1])
                w_sel = 4'b1111;
            else if (r_size[0])
                w_sel = r_lsb[1] ? 4'b1100 : 4'b0011;
            else
                w_sel = 4'b0001 << r_lsb;
        end
    end

    always_comb begin
        w_wdat = r_data;
        if (!r_size[1]) begin
            if (r_size[0])
                w_wdat = {2{r_data[15:0]}};
            else
                w_wdat = {4{r_data[7:0]}};
        end
    end

    assign io.o_ready    = (r_state == S_READY);
    assign io.o_wb_cyc   = (r_state == S_BUS);
    assign io.o_wb_we    = (r_state == S_BUS);
    assign io.o_wb_sel   = w_sel;
    assign io.o_wb_dat   = w_wdat;
    assign io.o_done     = r_done;
    assign io.o_misalign = r_misalign;

endmodule

// File: tb/tb_oerv_store_ser2par.sv
// Scoreboard bench for oerv_store_ser2par: drives one stimulus stream into an
// aligned-checking instance (u_dut1) and a non-checking instance (u_dut0).
module tb_oerv_store_ser2par;

    typedef struct packed {
        logic        mis;
        logic [31:0] dat;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       t_dat_en = 1'b0;
    logic [1:0] t_cnt    = '0;
    logic [7:0] t_dat    = '0;
    logic [1:0] t_size   = '0;
    logic [1:0] t_lsb    = '0;
    logic       t_req    = 1'b0;
    logic       t_ack    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic        p_cyc[2] = '{1'b0, 1'b0};
    logic        p_mis[2] = '{1'b0, 1'b0};
    logic [31:0] f_dat[2];
    logic [3:0]  f_sel[2];
    logic        p_ack = 1'b0;
    logic        p_rst = 1'b1;

    oerv_store_ser2par_if if0 ();
    oerv_store_ser2par_if if1 ();

    assign if0.i_dat_en = t_dat_en;
    assign if0.i_cnt    = t_cnt;
    assign if0.i_dat    = t_dat;
    assign if0.i_size   = t_size;
    assign if0.i_lsb    = t_lsb;
    assign if0.i_req    = t_req;
    assign if0.i_wb_ack = t_ack;
    assign if1.i_dat_en = t_dat_en;
    assign if1.i_cnt    = t_cnt;
    assign if1.i_dat    = t_dat;
    assign if1.i_size   = t_size;
    assign if1.i_lsb    = t_lsb;
    assign if1.i_req    = t_req;
    assign if1.i_wb_ack = t_ack;

    oerv_store_ser2par #(.ALIGN_CHECK(1'b1)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .io    (if1)
    );

    oerv_store_ser2par #(.ALIGN_CHECK(1'b0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .io    (if0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic mis, input logic [31:0] d, input logic [3:0] s);
        return {mis, d, s};
    endfunction

    task automatic pop(input int i, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        if (i == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic mon(input int i, input logic cyc, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input logic done, input logic mis);
        exp_t e;
        bit   ok;
        check($sformatf("dut%0d we", i), we, cyc);
        check($sformatf("dut%0d done", i), done, p_cyc[i] && p_ack && !p_rst);
        if (cyc && !p_cyc[i]) begin
            pop(i, e, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dut%0d unexpected bus cycle: dat 0x%08h sel %b", i, dat, sel);
            end else begin
                check($sformatf("dut%0d bus-vs-misalign", i), e.mis, 1'b0);
                check($sformatf("dut%0d wb_dat", i), dat, e.dat);
                check($sformatf("dut%0d wb_sel", i), sel, e.sel);
            end
            f_dat[i] = dat;
            f_sel[i] = sel;
        end else if (cyc) begin
            check($sformatf("dut%0d dat stable", i), dat, f_dat[i]);
            check($sformatf("dut%0d sel stable", i), sel, f_sel[i]);
        end
        if (mis) begin
            check($sformatf("dut%0d misalign cyc", i), cyc, 1'b0);
            check($sformatf("dut%0d misalign width", i), p_mis[i], 1'b0);
            pop(i, e, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dut%0d unexpected misalign: got 1 expected 0", i);
            end else begin
                check($sformatf("dut%0d misalign-vs-bus", i), e.mis, 1'b1);
            end
        end
        p_cyc[i] = cyc;
        p_mis[i] = mis;
    endtask

    always @(negedge clk) begin
        mon(0, if0.o_wb_cyc, if0.o_wb_we, if0.o_wb_sel, if0.o_wb_dat, if0.o_done, if0.o_misalign);
        mon(1, if1.o_wb_cyc, if1.o_wb_we, if1.o_wb_sel, if1.o_wb_dat, if1.o_done, if1.o_misalign);
        p_ack = t_ack;
        p_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [1:0] c, input logic [7:0] d);
        t_dat_en = 1'b1;
        t_cnt    = c;
        t_dat    = d;
        tick();
        t_dat_en = 1'b0;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            send_byte(k[1:0], w[8*k +: 8]);
    endtask

    task automatic request(input logic [1:0] s, input logic [1:0] l);
        t_size = s;
        t_lsb  = l;
        t_req  = 1'b1;
        tick();
        t_req  = 1'b0;
    endtask

    task automatic wait_ack(input int d);
        repeat (d) tick();
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]  size;
        logic [1:0]  lsb;
        logic [31:0] dat;
        logic [3:0]  sel;
    } vec_t;

    vec_t aligned_v[4] = '{
        '{size: 2'b00, lsb: 2'b11, dat: 32'hEFEF_EFEF, sel: 4'b1000},
        '{size: 2'b00, lsb: 2'b01, dat: 32'hEFEF_EFEF, sel: 4'b0010},
        '{size: 2'b01, lsb: 2'b10, dat: 32'hBEEF_BEEF, sel: 4'b1100},
        '{size: 2'b01, lsb: 2'b00, dat: 32'hBEEF_BEEF, sel: 4'b0011}
    };

    // Expected results of the non-checking instance for misaligned requests
    vec_t misal_v[4] = '{
        '{size: 2'b01, lsb: 2'b01, dat: 32'hBEEF_BEEF, sel: 4'b0011},
        '{size: 2'b10, lsb: 2'b10, dat: 32'hDEAD_BEEF, sel: 4'b1111},
        '{size: 2'b10, lsb: 2'b01, dat: 32'hDEAD_BEEF, sel: 4'b1111},
        '{size: 2'b11, lsb: 2'b11, dat: 32'hDEAD_BEEF, sel: 4'b1111}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst ready1", if1.o_ready, 1'b0);
        check("rst cyc1", if1.o_wb_cyc, 1'b0);
        check("rst sel1", if1.o_wb_sel, 4'b0000);
        check("rst dat1", if1.o_wb_dat, 32'h0);
        check("rst done1", if1.o_done, 1'b0);
        check("rst mis1", if1.o_misalign, 1'b0);
        check("rst ready0", if0.o_ready, 1'b0);
        check("rst dat0", if0.o_wb_dat, 32'h0);

        // Word store with i_req held through the fill: cyc two cycles after byte 3
        q1.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        q0.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        t_size = 2'b10;
        t_lsb  = 2'b00;
        t_req  = 1'b1;
        fill(32'hDEAD_BEEF);
        check("latency ready", if1.o_ready, 1'b1);
        check("latency cyc early", if1.o_wb_cyc, 1'b0);
        tick();
        t_req = 1'b0;
        check("latency cyc", if1.o_wb_cyc, 1'b1);
        check("latency ready low", if1.o_ready, 1'b0);
        wait_ack(3);
        check("word done", if1.o_done, 1'b1);
        check("word cyc low", if1.o_wb_cyc, 1'b0);
        tick();
        check("done pulse width", if1.o_done, 1'b0);

        // Request while IDLE is ignored
        request(2'b10, 2'b00);
        check("idle req cyc", if1.o_wb_cyc, 1'b0);

        for (int v = 0; v < 4; v++) begin
            fill(32'hDEAD_BEEF);
            q1.push_back(mk(1'b0, aligned_v[v].dat, aligned_v[v].sel));
            q0.push_back(mk(1'b0, aligned_v[v].dat, aligned_v[v].sel));
            request(aligned_v[v].size, aligned_v[v].lsb);
            wait_ack(v);
        end

        for (int v = 0; v < 4; v++) begin
            fill(32'hDEAD_BEEF);
            q1.push_back(mk(1'b1, 32'h0, 4'b0000));
            q0.push_back(mk(1'b0, misal_v[v].dat, misal_v[v].sel));
            request(misal_v[v].size, misal_v[v].lsb);
            check("misalign pulse", if1.o_misalign, 1'b1);
            check("misalign no cyc", if1.o_wb_cyc, 1'b0);
            check("misalign to idle", if1.o_ready, 1'b0);
            check("nocheck cyc", if0.o_wb_cyc, 1'b1);
            wait_ack(0);
        end

        // Fill disruption: out-of-order byte ignored, byte 0 restarts
        send_byte(2'd0, 8'hAA);
        send_byte(2'd1, 8'hBB);
        send_byte(2'd3, 8'hCC);
        check("ooo not ready", if1.o_ready, 1'b0);
        send_byte(2'd0, 8'h11);
        send_byte(2'd1, 8'h22);
        send_byte(2'd2, 8'h33);
        check("refill not ready", if1.o_ready, 1'b0);
        send_byte(2'd3, 8'h44);
        check("refill ready", if1.o_ready, 1'b1);
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        check("ack outside bus", if1.o_ready, 1'b1);
        q1.push_back(mk(1'b0, 32'h4433_2211, 4'b1111));
        q0.push_back(mk(1'b0, 32'h4433_2211, 4'b1111));
        request(2'b10, 2'b00);
        wait_ack(1);

        // Request and byte 0 together in READY: request wins
        fill(32'hDEAD_BEEF);
        q1.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        q0.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        t_dat_en = 1'b1;
        t_cnt    = 2'd0;
        t_dat    = 8'h99;
        request(2'b10, 2'b00);
        t_dat_en = 1'b0;
        wait_ack(0);

        // Long ack with bytes arriving during BUS
        fill(32'hDEAD_BEEF);
        q1.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        q0.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        request(2'b10, 2'b00);
        for (int k = 0; k < 5; k++)
            send_byte(k[1:0], 8'h55 + k[7:0]);
        wait_ack(0);
        check("bus bytes ignored", if1.o_wb_dat, 32'hDEAD_BEEF);

        // Ack in the first BUS cycle
        fill(32'h4433_2211);
        q1.push_back(mk(1'b0, 32'h4433_2211, 4'b1111));
        q0.push_back(mk(1'b0, 32'h4433_2211, 4'b1111));
        request(2'b10, 2'b00);
        wait_ack(0);
        check("fast ack done", if1.o_done, 1'b1);
        check("fast ack cyc", if1.o_wb_cyc, 1'b0);

        // Reset mid-BUS, coincident with ack: no done
        fill(32'hDEAD_BEEF);
        q1.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        q0.push_back(mk(1'b0, 32'hDEAD_BEEF, 4'b1111));
        request(2'b10, 2'b00);
        tick();
        rst   = 1'b1;
        t_ack = 1'b1;
        tick();
        rst   = 1'b0;
        t_ack = 1'b0;
        check("rst bus cyc", if1.o_wb_cyc, 1'b0);
        check("rst bus done", if1.o_done, 1'b0);
        check("rst bus ready", if1.o_ready, 1'b0);
        check("rst bus dat", if1.o_wb_dat, 32'h0);
        tick();
        fill(32'h4433_2211);
        q1.push_back(mk(1'b0, 32'h4433_2211, 4'b1111));
        q0.push_back(mk(1'b0, 32'h4433_2211, 4'b1111));
        request(2'b10, 2'b00);
        wait_ack(1);
        check("post rst done", if1.o_done, 1'b1);

        repeat (3) tick();
        check("q1 drained", q1.size(), 0);
        check("q0 drained", q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
